// File: rtl/alu_issue_arbiter_if.sv
// Shared ALU issue bundle: two requesters, shared-ALU drive/return, registered result.
// Package carries the ALU operation encoding used by requesters and the ALU.
package alu_issue_pkg;
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_BEQ = 3'd5,
    ALU_BNE = 3'd6
  } alu_operation_t;
endpackage

interface alu_issue_arbiter_if #(parameter int XLEN = 32, parameter int TAG_W = 4);
  import alu_issue_pkg::*;

  logic [1:0]                  req_valid_i;
  logic [1:0]                  req_ready_o;
  logic [1:0][XLEN-1:0]        req_operand_A_i;
  logic [1:0][XLEN-1:0]        req_operand_B_i;
  alu_operation_t [1:0]        req_operation_i;
  logic [1:0][TAG_W-1:0]       req_tag_i;

  logic [XLEN-1:0]             alu_operand_A_o;
  logic [XLEN-1:0]             alu_operand_B_o;
  alu_operation_t              alu_operation_o;
  logic                        alu_valid_o;
  logic [XLEN-1:0]             alu_result_i;
  logic                        alu_pc_write_i;

  logic                        res_valid_o;
  logic                        res_ready_i;
  logic [XLEN-1:0]             res_data_o;
  logic                        res_pc_write_o;
  logic [TAG_W-1:0]            res_tag_o;
  logic                        res_port_o;

  // Arbiter side
  modport slave (
    input  req_valid_i, req_operand_A_i, req_operand_B_i, req_operation_i, req_tag_i,
    input  alu_result_i, alu_pc_write_i, res_ready_i,
    output req_ready_o, alu_operand_A_o, alu_operand_B_o, alu_operation_o, alu_valid_o,
    output res_valid_o, res_data_o, res_pc_write_o, res_tag_o, res_port_o
  );

  // Requester / ALU / consumer side
  modport master (
    output req_valid_i, req_operand_A_i, req_operand_B_i, req_operation_i, req_tag_i,
    output alu_result_i, alu_pc_write_i, res_ready_i,
    input  req_ready_o, alu_operand_A_o, alu_operand_B_o, alu_operation_o, alu_valid_o,
    input  res_valid_o, res_data_o, res_pc_write_o, res_tag_o, res_port_o
  );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Round-robin arbiter feeding two issue ports into one shared ALU, with a
// single-entry registered result stage that supports drain-and-refill each cycle.
module alu_issue_arbiter #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               flush_i,
  alu_issue_arbiter_if.slave bus
);

  logic             prio;
  logic             can_issue;
  logic             any_vld;
  logic             gnt_idx;
  logic             xfer;
  logic             sel;

  logic             res_valid_q;
  logic [XLEN-1:0]  res_data_q;
  logic             res_pc_write_q;
  logic [TAG_W-1:0] res_tag_q;
  logic             res_port_q;

  // rst_n_i gates issue so nothing is handed out while reset is held.
  always_comb begin
    can_issue = rst_n_i && (!res_valid_q || bus.res_ready_i) && !flush_i;
    any_vld   = |bus.req_valid_i;
    gnt_idx   = (&bus.req_valid_i) ? prio : bus.req_valid_i[1];
    xfer      = can_issue && any_vld;
    sel       = xfer && gnt_idx;
  end

  assign bus.req_ready_o     = xfer ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
  assign bus.alu_valid_o     = xfer;
  assign bus.alu_operand_A_o = bus.req_operand_A_i[sel];
  assign bus.alu_operand_B_o = bus.req_operand_B_i[sel];
  assign bus.alu_operation_o = bus.req_operation_i[sel];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prio           <= 1'b0;
      res_valid_q    <= 1'b0;
      res_data_q     <= '0;
      res_pc_write_q <= 1'b0;
      res_tag_q      <= '0;
      res_port_q     <= 1'b0;
    end else if (xfer) begin
      prio           <= ~gnt_idx;
      res_valid_q    <= 1'b1;
      res_data_q     <= bus.alu_result_i;
      res_pc_write_q <= bus.alu_pc_write_i;
      res_tag_q      <= bus.req_tag_i[gnt_idx];
      res_port_q     <= gnt_idx;
    end else if (flush_i || bus.res_ready_i) begin
      res_valid_q    <= 1'b0;
    end
  end

  assign bus.res_valid_o    = res_valid_q;
  assign bus.res_data_o     = res_data_q;
  assign bus.res_pc_write_o = res_pc_write_q;
  assign bus.res_tag_o      = res_tag_q;
  assign bus.res_port_o     = res_port_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Scenario bench for alu_issue_arbiter: behavioural ALU, scoreboard of
// expected results filled at each observed transfer and drained one cycle later.
module tb_alu_issue_arbiter;
  import alu_issue_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic        pc;
    logic [3:0]  tag;
    logic        port;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  bit   pend = 1'b0;

  alu_issue_arbiter_if #(.XLEN(32), .TAG_W(4)) bus();

  alu_issue_arbiter #(.XLEN(32), .TAG_W(4)) u_dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .flush_i (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] alu_model(input alu_operation_t op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_ADD: return {1'b0, a + b};
      ALU_SUB: return {1'b0, a - b};
      ALU_AND: return {1'b0, a & b};
      ALU_OR:  return {1'b0, a | b};
      ALU_XOR: return {1'b0, a ^ b};
      ALU_BEQ: return {(a == b), 32'd0};
      ALU_BNE: return {(a != b), 32'd0};
      default: return 33'd0;
    endcase
  endfunction

  always_comb {bus.alu_pc_write_i, bus.alu_result_i} =
    alu_model(bus.alu_operation_o, bus.alu_operand_A_o, bus.alu_operand_B_o);

  // Scoreboard monitor: compare last cycle's transfer, then record this cycle's.
  always @(negedge clk) begin : monitor
    exp_t e;
    logic [32:0] r;
    if (rst_n) begin
      if (pend) begin
        pend = 1'b0;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL sb_empty: result expected but scoreboard empty");
        end else begin
          e = q.pop_front();
          if (bus.res_valid_o !== 1'b1 || bus.res_data_o !== e.data || bus.res_pc_write_o !== e.pc ||
              bus.res_tag_o !== e.tag || bus.res_port_o !== e.port) begin
            errors++;
            $display("FAIL sb_result: got v=%b d=%0h pc=%b tag=%0h port=%b want v=1 d=%0h pc=%b tag=%0h port=%b",
                     bus.res_valid_o, bus.res_data_o, bus.res_pc_write_o, bus.res_tag_o, bus.res_port_o,
                     e.data, e.pc, e.tag, e.port);
          end
        end
      end
      checks++;
      if (bus.req_ready_o === 2'b11) begin
        errors++;
        $display("FAIL ready_onehot: got %b want at most one bit", bus.req_ready_o);
      end
      checks++;
      if (bus.alu_valid_o !== |(bus.req_valid_i & bus.req_ready_o)) begin
        errors++;
        $display("FAIL alu_valid_xfer: got %b want %b", bus.alu_valid_o, |(bus.req_valid_i & bus.req_ready_o));
      end
      for (int p = 0; p < 2; p++) begin
        if (bus.req_valid_i[p] && bus.req_ready_o[p]) begin
          r = alu_model(bus.req_operation_i[p], bus.req_operand_A_i[p], bus.req_operand_B_i[p]);
          e.data = r[31:0];
          e.pc   = r[32];
          e.tag  = bus.req_tag_i[p];
          e.port = p[0];
          q.push_back(e);
          pend = 1'b1;
        end
      end
    end
  end

  task automatic set_port(input int p, input logic v, input alu_operation_t op,
                          input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    bus.req_valid_i[p]     = v;
    bus.req_operation_i[p] = op;
    bus.req_operand_A_i[p] = a;
    bus.req_operand_B_i[p] = b;
    bus.req_tag_i[p]       = tag;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_port(0, 1'b1, ALU_ADD, 32'd1, 32'd1, 4'd1);
    set_port(1, 1'b1, ALU_ADD, 32'd2, 32'd2, 4'd2);
    bus.res_ready_i = 1'b1;
    #12;
    checks++;
    if (bus.res_valid_o !== 1'b0 || bus.res_data_o !== 32'd0 || bus.res_pc_write_o !== 1'b0 ||
        bus.res_tag_o !== 4'd0 || bus.res_port_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_res: got v=%b d=%0h pc=%b tag=%0h port=%b want all zero",
               bus.res_valid_o, bus.res_data_o, bus.res_pc_write_o, bus.res_tag_o, bus.res_port_o);
    end
    checks++;
    if (bus.req_ready_o !== 2'b00 || bus.alu_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got rdy=%b alu_v=%b want 00/0", bus.req_ready_o, bus.alu_valid_o);
    end
    bus.req_valid_i = 2'b00;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_alternate();
    for (int i = 0; i < 6; i++) begin
      set_port(0, 1'b1, ALU_ADD, $urandom, $urandom, 4'(i));
      set_port(1, 1'b1, ALU_XOR, $urandom, $urandom, 4'(i + 8));
      @(negedge clk);
      checks++;
      if (bus.req_ready_o !== ((i % 2) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL alt_grant[%0d]: got %b want %b", i, bus.req_ready_o, (i % 2) ? 2'b10 : 2'b01);
      end
      if (i > 0) begin
        checks++;
        if (bus.res_valid_o !== 1'b1 || bus.res_port_o !== 1'((i - 1) % 2)) begin
          errors++;
          $display("FAIL alt_result[%0d]: got v=%b port=%b want v=1 port=%0d", i, bus.res_valid_o,
                   bus.res_port_o, (i - 1) % 2);
        end
      end
      step();
    end
    bus.req_valid_i = 2'b00;
    step();
  endtask

  task automatic test_single();
    set_port(0, 1'b1, ALU_ADD, 32'd5, 32'd7, 4'd3);
    @(negedge clk);
    checks++;
    if (bus.req_ready_o !== 2'b01 || bus.alu_valid_o !== 1'b1 || bus.alu_operand_A_o !== 32'd5) begin
      errors++;
      $display("FAIL single_issue: got rdy=%b alu_v=%b A=%0d want 01/1/5", bus.req_ready_o, bus.alu_valid_o,
               bus.alu_operand_A_o);
    end
    step();
    bus.req_valid_i = 2'b00;
    checks++;
    if (bus.res_valid_o !== 1'b1 || bus.res_data_o !== 32'd12 || bus.res_tag_o !== 4'd3 || bus.res_port_o !== 1'b0) begin
      errors++;
      $display("FAIL single_result: got v=%b d=%0d tag=%0d port=%b want 1/12/3/0", bus.res_valid_o,
               bus.res_data_o, bus.res_tag_o, bus.res_port_o);
    end
    step();
    checks++;
    if (bus.res_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: got v=%b want 0", bus.res_valid_o);
    end
  endtask

  task automatic test_backpressure();
    bus.res_ready_i = 1'b0;
    set_port(0, 1'b1, ALU_ADD, 32'd1, 32'd2, 4'd1);
    set_port(1, 1'b1, ALU_SUB, 32'd20, 32'd5, 4'd2);
    @(negedge clk);
    checks++;
    if (bus.req_ready_o !== 2'b10) begin
      errors++;
      $display("FAIL bp_first_grant: got %b want 10", bus.req_ready_o);
    end
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.req_ready_o !== 2'b00 || bus.alu_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall[%0d]: got rdy=%b alu_v=%b want 00/0", i, bus.req_ready_o, bus.alu_valid_o);
      end
      checks++;
      if (bus.res_valid_o !== 1'b1 || bus.res_data_o !== 32'd15 || bus.res_tag_o !== 4'd2 || bus.res_port_o !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%0d tag=%0d port=%b want 1/15/2/1", i, bus.res_valid_o,
                 bus.res_data_o, bus.res_tag_o, bus.res_port_o);
      end
      step();
    end
    bus.res_ready_i = 1'b1;
    #1;
    checks++;
    if (bus.req_ready_o !== 2'b01 || bus.alu_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got rdy=%b alu_v=%b want 01/1", bus.req_ready_o, bus.alu_valid_o);
    end
    step();
    bus.req_valid_i = 2'b00;
    step();
  endtask

  task automatic test_branch();
    set_port(1, 1'b1, ALU_BEQ, 32'd9, 32'd9, 4'd5);
    step();
    checks++;
    if (bus.res_pc_write_o !== 1'b1 || bus.res_data_o !== 32'd0 || bus.res_port_o !== 1'b1 || bus.res_tag_o !== 4'd5) begin
      errors++;
      $display("FAIL beq_taken: got pc=%b d=%0h port=%b tag=%0d want 1/0/1/5", bus.res_pc_write_o,
               bus.res_data_o, bus.res_port_o, bus.res_tag_o);
    end
    set_port(1, 1'b1, ALU_BNE, 32'd9, 32'd9, 4'd6);
    step();
    bus.req_valid_i = 2'b00;
    checks++;
    if (bus.res_pc_write_o !== 1'b0 || bus.res_data_o !== 32'd0 || bus.res_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL bne_not_taken: got pc=%b d=%0h v=%b want 0/0/1", bus.res_pc_write_o, bus.res_data_o,
               bus.res_valid_o);
    end
    step();
  endtask

  task automatic test_flush();
    set_port(0, 1'b1, ALU_ADD, 32'd10, 32'd20, 4'd7);
    step();
    set_port(1, 1'b1, ALU_OR, 32'h0f, 32'hf0, 4'd8);
    flush = 1'b1;
    #1;
    checks++;
    if (bus.req_ready_o !== 2'b00 || bus.alu_valid_o !== 1'b0 || bus.res_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_block: got rdy=%b alu_v=%b res_v=%b want 00/0/1", bus.req_ready_o,
               bus.alu_valid_o, bus.res_valid_o);
    end
    step();
    checks++;
    if (bus.res_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear: got v=%b want 0", bus.res_valid_o);
    end
    flush = 1'b0;
    #1;
    checks++;
    if (bus.req_ready_o !== 2'b10) begin
      errors++;
      $display("FAIL flush_prio: got %b want 10", bus.req_ready_o);
    end
    step();
    checks++;
    if (bus.req_ready_o !== 2'b01 || bus.res_port_o !== 1'b1 || bus.res_data_o !== 32'hff) begin
      errors++;
      $display("FAIL flush_after: got rdy=%b port=%b d=%0h want 01/1/ff", bus.req_ready_o, bus.res_port_o,
               bus.res_data_o);
    end
    bus.req_valid_i = 2'b00;
    step();
  endtask

  task automatic test_async_reset();
    bus.res_ready_i = 1'b0;
    set_port(0, 1'b1, ALU_SUB, 32'd50, 32'd8, 4'd9);
    step();
    bus.req_valid_i = 2'b11;
    checks++;
    if (bus.res_valid_o !== 1'b1 || bus.res_data_o !== 32'd42) begin
      errors++;
      $display("FAIL arst_setup: got v=%b d=%0d want 1/42", bus.res_valid_o, bus.res_data_o);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.res_valid_o !== 1'b0 || bus.res_data_o !== 32'd0 || bus.res_tag_o !== 4'd0 || bus.res_port_o !== 1'b0 ||
        bus.req_ready_o !== 2'b00 || bus.alu_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL arst_immediate: got v=%b d=%0d tag=%0d port=%b rdy=%b alu_v=%b want all zero",
               bus.res_valid_o, bus.res_data_o, bus.res_tag_o, bus.res_port_o, bus.req_ready_o, bus.alu_valid_o);
    end
    q.delete();
    pend = 1'b0;
    rst_n = 1'b1;
    bus.res_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready_o !== 2'b01) begin
      errors++;
      $display("FAIL arst_first_grant: got %b want 01", bus.req_ready_o);
    end
    step();
    bus.req_valid_i = 2'b00;
    step();
    step();
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.req_valid_i     = 2'b00;
    bus.req_operand_A_i = '0;
    bus.req_operand_B_i = '0;
    bus.req_tag_i       = '0;
    bus.req_operation_i[0] = ALU_ADD;
    bus.req_operation_i[1] = ALU_ADD;
    bus.res_ready_i     = 1'b1;
    test_reset();
    test_alternate();
    test_single();
    test_backpressure();
    test_branch();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_issue_arbiter.md
ALU_ISSUE_ARBITER -- requirements
Module: alu_issue_arbiter

Interface
Parameters:
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter TAG_W, default 4, giving the width of the destination tag carried with each request.

Ports:
REQ-003 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n_i  input  1  reset; asynchronous and active-low.
REQ-005 flush_i  input  1  synchronous pipeline flush.
REQ-006 req_valid_i  input  2  per-requester valid (bit 0 = integer issue port, bit 1 = branch issue port).
REQ-007 req_ready_o  output  2  per-requester ready.
REQ-008 req_operand_A_i, req_operand_B_i  input  2 x XLEN  per-requester operands.
REQ-009 req_operation_i  input  2 x alu_operation_t  per-requester ALU operation.
REQ-010 req_tag_i  input  2 x TAG_W  per-requester destination tag.
REQ-011 alu_operand_A_o, alu_operand_B_o  output  XLEN  operands driven to the shared ALU.
REQ-012 alu_operation_o  output  alu_operation_t  operation driven to the shared ALU.
REQ-013 alu_valid_o  output  1  high when a request is being issued this cycle.
REQ-014 alu_result_i  input  XLEN  ALU result, combinational from the alu_* outputs.
REQ-015 alu_pc_write_i  input  1  ALU branch-taken/PC-write flag, combinational.
REQ-016 res_valid_o  output  1  result register holds a valid entry.
REQ-017 res_ready_i  input  1  downstream accepts the result.
REQ-018 res_data_o  output  XLEN  registered result.
REQ-019 res_pc_write_o  output  1  registered PC-write flag.
REQ-020 res_tag_o  output  TAG_W  tag of the request that produced the result.
REQ-021 res_port_o  output  1  index of the requester that produced the result.

Function
REQ-022 can_issue SHALL be defined as (!res_valid_o || res_ready_i) && !flush_i.
REQ-023 Grant SHALL be round-robin with a 1-bit priority pointer prio:
- if both requesters are valid, port prio SHALL win;
- if only one requester is valid, that port SHALL win.
REQ-024 req_ready_o[i] SHALL be 1 only when can_issue is 1 and port i holds the grant; at most one bit SHALL be high in any cycle.
REQ-025 A transfer SHALL occur on port i when req_valid_i[i] && req_ready_o[i].
REQ-026 On a transfer, prio SHALL become the inverse of the granted index on the next edge; otherwise prio SHALL hold.
REQ-027 alu_* outputs SHALL be driven combinationally with the granted port's fields.
REQ-028 When no port is granted, alu_* SHALL carry port 0 fields and alu_valid_o SHALL be 0.
REQ-029 alu_valid_o SHALL equal 1 exactly in cycles in which a transfer occurs.
REQ-030 On a transfer, the next edge SHALL load res_data_o <= alu_result_i, res_pc_write_o <= alu_pc_write_i, res_tag_o <= granted tag, res_port_o <= granted index, and res_valid_o <= 1.
REQ-031 Latency from transfer to res_valid_o SHALL be exactly 1 cycle.
REQ-032 Sustained throughput SHALL be 1 result per cycle while res_ready_i = 1.
REQ-033 If res_valid_o && res_ready_i and no transfer occurs, res_valid_o SHALL clear on the next edge.
REQ-034 Simultaneous drain and transfer SHALL keep res_valid_o = 1 with the new contents loaded.
REQ-035 While res_valid_o && !res_ready_i, all res_* outputs SHALL hold stable and req_ready_o SHALL be 0.
REQ-036 flush_i = 1 SHALL clear res_valid_o on the next edge, force req_ready_o = 0 that cycle, and leave prio unchanged; flush_i SHALL take precedence over any drain.
REQ-037 Results of conditional-branch operations SHALL be passed through unaltered (data 0, PC-write flag as produced by the ALU).
REQ-038 No requester holding valid continuously SHALL wait more than 1 accepted transfer of the other port before being granted.

Reset
REQ-039 Asserting rst_n_i low SHALL immediately, independent of clk_i, set res_valid_o = 0, res_data_o = 0, res_pc_write_o = 0, res_tag_o = 0, res_port_o = 0, and prio = 0.
REQ-040 While rst_n_i is low, req_ready_o and alu_valid_o SHALL be 0.
REQ-041 Reset asserted mid-operation SHALL discard the held result with no partial state retained.
REQ-042 Deassertion of rst_n_i SHALL take effect at the next rising edge of clk_i.

Verification
REQ-043 Both ports valid every cycle, res_ready_i = 1, from reset -> grants alternate 0,1,0,1; res_port_o follows one cycle later; one result per cycle.
REQ-044 Port 0 only, ADD with A = 5, B = 7, tag 3 -> next cycle res_valid_o = 1, res_data_o = 12, res_tag_o = 3, res_port_o = 0.
REQ-045 Result held with res_ready_i = 0 for 3 cycles while both ports are valid -> req_ready_o = 00 and res_* stable; on res_ready_i = 1, the next request issues in that same cycle.
REQ-046 Port 1 BEQ with A = B = 9 -> res_pc_write_o = 1, res_data_o = 0; BNE with the same operands -> res_pc_write_o = 0.
REQ-047 flush_i pulsed while res_valid_o = 1 and both ports valid -> no transfer that cycle, res_valid_o = 0 next cycle, grant order unchanged afterwards.
REQ-048 rst_n_i pulsed low asynchronously between clock edges with res_valid_o = 1 and prio = 1 -> res_valid_o falls immediately; first grant after reset goes to port 0.
